// File: rtl/keypad_scanner_if.sv
// Keypad matrix signals between the row scanner and its consumer.
// master drives the rows and key reports; slave drives the column lines.
interface keypad_scanner_if;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  columnas,
        output filas,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output columnas,
        input  filas,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: one-cold row drive, column debounce,
// one-cycle key strobe and release wait before resuming the scan.
module keypad_scanner #(
    parameter int SCAN_DIV        = 27_000,
    parameter int DEBOUNCE_CYCLES = 270_000
) (
    input logic             clk,
    input logic             n_reset,
    keypad_scanner_if.master kp
);
    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    localparam logic [31:0] SLOT_LAST = 32'(SCAN_DIV - 1);
    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);

    state_t      state, state_d;
    logic [1:0]  row_idx, row_idx_d;
    logic [1:0]  col_idx;
    logic [31:0] slot_cnt, slot_cnt_d;
    logic [31:0] deb_cnt, deb_cnt_d;
    logic [3:0]  pat, pat_d;
    logic [3:0]  col_m, col_s;
    logic [3:0]  code, code_d;
    logic        valid, valid_d;
    logic        held, held_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= SCAN;
            row_idx  <= '0;
            slot_cnt <= '0;
            deb_cnt  <= '0;
            pat      <= '0;
            col_m    <= '0;
            col_s    <= '0;
            code     <= '0;
            valid    <= 1'b0;
            held     <= 1'b0;
        end else begin
            state    <= state_d;
            row_idx  <= row_idx_d;
            slot_cnt <= slot_cnt_d;
            deb_cnt  <= deb_cnt_d;
            pat      <= pat_d;
            col_m    <= kp.columnas;
            col_s    <= col_m;
            code     <= code_d;
            valid    <= valid_d;
            held     <= held_d;
        end
    end

    // Lowest-numbered closed column wins when several share a row.
    always_comb begin
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) col_idx = 2'(i);
        end
    end

    always_comb begin
        state_d    = state;
        row_idx_d  = row_idx;
        slot_cnt_d = slot_cnt;
        deb_cnt_d  = deb_cnt;
        pat_d      = pat;
        code_d     = code;
        valid_d    = 1'b0;
        held_d     = held;
        unique case (state)
            SCAN: begin
                if (slot_cnt == SLOT_LAST) begin
                    slot_cnt_d = '0;
                    deb_cnt_d  = '0;
                    if (col_s != 4'hF) begin
                        pat_d   = col_s;
                        state_d = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx + 2'd1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt + 32'd1;
                end
            end
            DEBOUNCE: begin
                if (col_s != pat) begin
                    state_d    = SCAN;
                    slot_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d    = PRESSED;
                    slot_cnt_d = '0;
                    deb_cnt_d  = '0;
                    valid_d    = 1'b1;
                    held_d     = 1'b1;
                    code_d     = {row_idx, col_idx};
                end else begin
                    deb_cnt_d = deb_cnt + 32'd1;
                end
            end
            PRESSED: begin
                // Any closed contact restarts the release window.
                if (col_s != 4'hF) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_d    = SCAN;
                    held_d     = 1'b0;
                    row_idx_d  = row_idx + 2'd1;
                    slot_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt + 32'd1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign kp.filas     = ~(4'b0001 << row_idx);
    assign kp.key_code  = code;
    assign kp.key_valid = valid;
    assign kp.key_held  = held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 switch-matrix model drives the columns
// from the row drive; key reports are checked against expected keys.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic n_reset;
    logic [15:0] keys;
    logic [3:0] cols;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [3:0] strobe_codes[$];
    int strobe_cyc[$];
    bit prev_kv = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .kp(kp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A closed switch pulls its column low while its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kp.filas[r]) cols = cols & ~keys[r*4 +: 4];
        end
    end
    assign kp.columnas = cols;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("one_cold", $countones(~kp.filas), 1);
        if (n_reset && kp.key_valid) begin
            chk("kv_single", prev_kv, 0);
            strobe_codes.push_back(kp.key_code);
            strobe_cyc.push_back(cyc);
        end
        prev_kv = kp.key_valid;
    end

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] v;
        v = 4'hF;
        v[r] = 1'b0;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int n0, input int budget,
                               input string tag);
        int b;
        b = 0;
        while (strobe_codes.size() == n0 && b < budget) begin
            tick(1);
            b++;
        end
        chk(tag, 32'(strobe_codes.size() > n0), 1);
    endtask

    task automatic wait_release(input int budget, input string tag);
        int b;
        b = 0;
        while (kp.key_held && b < budget) begin
            tick(1);
            b++;
        end
        chk(tag, 32'(kp.key_held), 0);
    endtask

    task automatic wait_row(input int r, input int budget);
        int b;
        b = 0;
        while (kp.filas != row_pat(r) && b < budget) begin
            tick(1);
            b++;
        end
        chk("wait_row", kp.filas, row_pat(r));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ts, n0;
        int r, idx;
        logic [3:0] m, lsb, expc;

        n_reset = 1'b0;
        keys = '0;
        tick(3);
        chk("rst_filas", kp.filas, 4'b1110);
        chk("rst_code", kp.key_code, 0);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_held", kp.key_held, 0);

        // Idle scan: each row for SD cycles, in order.
        n_reset = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            chk("idle_filas", kp.filas, row_pat((k / SD) % 4));
            tick(1);
        end
        chk("idle_no_kv", strobe_codes.size(), 0);

        // Clean press of row 2 col 2, reached on the second lap.
        keys[2*4+2] = 1'b1;
        tick(40);
        chk("clean_count", strobe_codes.size(), 1);
        if (strobe_codes.size() > 0) begin
            chk("clean_code", strobe_codes[0], 4'b1010);
            chk("clean_lat", strobe_cyc[0] - t0,
                SD * (4 + 2) + (SD - 1) + DB + 1);
        end
        chk("clean_held", kp.key_held, 1);
        keys = '0;
        tick(2 + DB - 1);
        chk("clean_held_pre", kp.key_held, 1);
        tick(1);
        chk("clean_held_drop", kp.key_held, 0);
        chk("clean_next_row", kp.filas, row_pat(3));

        // Bounce on press, row 0 col 1.
        wait_row(0, 20);
        n0 = strobe_codes.size();
        keys[1] = 1'b1;
        tick(3);
        keys[1] = 1'b0;
        tick(2);
        keys[1] = 1'b1;
        ts = cyc;
        chk("bp_no_early", strobe_codes.size(), n0);
        wait_strobe(n0, 60, "bp_strobe");
        if (strobe_codes.size() > n0) begin
            chk("bp_code", strobe_codes[n0], 4'b0001);
            chk("bp_steady", 32'(strobe_cyc[n0] - ts >= DB), 1);
        end

        // Bounce on release.
        tick(3);
        keys = '0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("br_held", kp.key_held, 1);
        end
        keys[1] = 1'b1;
        tick(1);
        chk("br_held", kp.key_held, 1);
        keys[1] = 1'b0;
        tick(2 + DB - 1);
        chk("br_held_pre", kp.key_held, 1);
        tick(1);
        chk("br_held_drop", kp.key_held, 0);
        chk("br_count", strobe_codes.size(), n0 + 1);

        // Two keys on row 1: columns 0 and 3.
        n0 = strobe_codes.size();
        keys[4+0] = 1'b1;
        keys[4+3] = 1'b1;
        wait_strobe(n0, 60, "mk_strobe");
        if (strobe_codes.size() > n0)
            chk("mk_code", strobe_codes[n0], 4'b0100);
        keys = '0;
        wait_release(40, "mk_release");

        // Reset while debouncing row 2 col 1.
        keys[2*4+1] = 1'b1;
        wait_row(2, 20);
        tick(SD + 2);
        chk("mrd_pre_held", kp.key_held, 0);
        #2 n_reset = 1'b0;
        #1;
        chk("mrd_filas", kp.filas, 4'b1110);
        chk("mrd_code", kp.key_code, 0);
        chk("mrd_valid", kp.key_valid, 0);
        chk("mrd_held", kp.key_held, 0);
        keys = '0;
        tick(2);
        n_reset = 1'b1;
        n0 = strobe_codes.size();
        tick(40);
        chk("mrd_no_kv", strobe_codes.size(), n0);
        chk("mrd_held_idle", kp.key_held, 0);

        // Random presses with optional bounce on press and release.
        for (int it = 0; it < 12; it++) begin
            r = int'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
            lsb = m & (~m + 4'd1);
            idx = (lsb == 4'd1) ? 0 : (lsb == 4'd2) ? 1 :
                  (lsb == 4'd4) ? 2 : 3;
            expc = {r[1:0], idx[1:0]};
            n0 = strobe_codes.size();
            keys[r*4 +: 4] = m;
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, 6)));
                keys[r*4 +: 4] = '0;
                tick(1);
                keys[r*4 +: 4] = m;
            end
            wait_strobe(n0, 200, "rnd_strobe");
            if (strobe_codes.size() > n0)
                chk("rnd_code", strobe_codes[n0], expc);
            chk("rnd_held", kp.key_held, 1);
            tick(int'($urandom_range(1, 20)));
            keys = '0;
            if ($urandom_range(0, 1) == 1) begin
                tick(int'($urandom_range(1, DB - 3)));
                keys[r*4 +: 4] = m;
                tick(1);
                keys = '0;
            end
            wait_release(40, "rnd_release");
            chk("rnd_one_strobe", strobe_codes.size() - n0, 1);
            tick(int'($urandom_range(1, 10)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
